mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: instruction fetch (IF) and data load/store (LS).
- Sits between the core datapath and the memory block. It is the step toward a multi-cycle core, where fetch and data access no longer have private combinational memories.
- Allows one outstanding transaction at a time over valid/ready request channels, with a response-valid return path.
- LS has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive cycles fetch may be denied before it is forced to win; legal range 1..15

Ports:
- SYS_clk  in  1  single clock, all state on posedge
- SYS_reset  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch address (PC)
- if_rsp_valid  out  1  fetch data valid, one-cycle pulse
- if_rsp_data  out  DATA_W  fetched instruction
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_write  in  1  1=store, 0=load
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_length  in  2  01=byte, 10=half, 11=word
- ls_signed  in  1  sign-extend loads
- ls_rsp_valid  out  1  load data / store ack, one-cycle pulse
- ls_rsp_data  out  DATA_W  load data; 0 for store ack
- mem_req_valid  out  1  one-cycle request pulse to memory
- mem_write  out  1  registered copy of the accepted request's write flag
- mem_addr  out  ADDR_W  registered copy of the accepted request's address
- mem_wdata  out  DATA_W  registered copy of the accepted request's store data
- mem_length  out  2  registered copy of the accepted request's length
- mem_signed  out  1  registered copy of the accepted request's signed flag
- mem_rsp_valid  in  1  memory completion (read data or write ack)
- mem_rsp_data  in  DATA_W  memory read data
- busy  out  1  a transaction is outstanding
- spurious_rsp  out  1  sticky: mem_rsp_valid seen while not busy

Behaviour:
- Reset values:
  - state = IDLE, starve_cnt = 0, owner = none.
  - All outputs 0, including spurious_rsp and all mem_* registers.
- States:
  - IDLE: no transaction outstanding.
  - WAIT_IF: fetch transaction outstanding.
  - WAIT_LS: load/store transaction outstanding.
- IDLE readiness (combinational):
  - force_if = (starve_cnt == STARVE_LIMIT).
  - ls_req_ready = ls_req_valid & !(force_if & if_req_valid).
  - if_req_ready = if_req_valid & (!ls_req_valid | force_if).
  - At most one ready is high per cycle. Both readies are 0 outside IDLE.
- Accept (valid & ready in IDLE):
  - Next cycle: mem_req_valid = 1 for exactly one cycle, and the mem_* fields are loaded from the winner.
  - State moves to WAIT_IF or WAIT_LS.
  - Fetch requests drive mem_write = 0, mem_length = 11, mem_signed = 0.
- Request field stability: requester inputs are sampled only at accept. mem_* fields hold stable until the next accept.
- starve_cnt:
  - Cleared on fetch accept.
  - Incremented (saturating at STARVE_LIMIT) on each cycle that if_req_valid = 1 and fetch is not accepted, including WAIT_LS cycles.
  - Unchanged otherwise.
- Completion:
  - mem_rsp_valid in WAIT_x drives x_rsp_valid = 1 combinationally in the same cycle.
  - WAIT_IF: if_rsp_data = mem_rsp_data. WAIT_LS: ls_rsp_data = mem_rsp_data, forced to 0 for stores.
  - State returns to IDLE at the next edge.
  - The earliest next accept is the cycle after completion. Minimum occupancy is 3 cycles per transaction when memory responds the cycle after mem_req_valid.
  - mem_rsp_valid in the same cycle as mem_req_valid is legal and completes the transaction.
- No timeout: a WAIT state holds indefinitely until mem_rsp_valid arrives.
- mem_rsp_valid in IDLE:
  - Ignored; no rsp_valid is produced.
  - spurious_rsp is set and stays set until reset.
- Reset mid-transaction:
  - Outstanding transaction is abandoned and the state returns to IDLE.
  - A late memory response after reset sets spurious_rsp; the bench must tolerate this.
- busy = (state != IDLE).
- Requesters may drop valid before ready without penalty; there is no request latching.

Decomposition:
- Shared package (alongside the existing `include` defines):
  - Length codes: LEN_NONE = 00, LEN_BYTE = 01, LEN_HALF = 10, LEN_WORD = 11.
  - Arbiter state encoding: IDLE, WAIT_IF, WAIT_LS.
  - Default STARVE_LIMIT.
- One natural sub-module, arb_starve_counter: saturating counter with inc, clr and at_limit.
- FSM and muxing stay in the top module.

Test Plan:
- Single fetch: if_req_valid with if_addr = 0x0000_0010; memory answers 0x0130_0093 one cycle after mem_req_valid → mem_req_valid pulses once with mem_addr = 0x10 and mem_length = 11; if_rsp_valid pulses once with data 0x0130_0093; busy is high for 2 cycles.
- Simultaneous requests with starve_cnt = 0 → LS wins: store of 0xDEADBEEF to 0x100 with length 10 appears on mem_*; ls_rsp_valid pulses with data 0; the fetch is granted in the next IDLE cycle.
- Starvation: ls_req_valid held high continuously, STARVE_LIMIT = 4, if_req_valid high → fetch is accepted once starve_cnt reaches 4 while ls_req_valid is still high; starve_cnt then reads 0.
- Memory delay: mem_rsp_valid withheld for 10 cycles → both readies stay 0 and busy stays 1; completion occurs exactly on the response cycle.
- Reset during WAIT_LS, then a late mem_rsp_valid → no ls_rsp_valid; spurious_rsp = 1; state is IDLE; all other outputs are 0.
- Signed byte load from 0x203: memory returns 0xFFFF_FF80 → mem_length = 01, mem_signed = 1, and ls_rsp_data = 0xFFFF_FF80 is passed through unmodified.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified memory port arbiter.
// Length codes, arbiter state encoding and default fetch starvation limit.
package mem_port_arbiter_pkg;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_IF = 2'd1;
  localparam logic [1:0] ST_WAIT_LS = 2'd2;

  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating fetch starvation counter.
// at_limit_o tells the arbiter to force a fetch grant.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [3:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == 4'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !at_limit_o)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one memory port.
// LS has priority; a starvation counter forces fetch progress.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_write,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [1:0]        ls_length,
  input  logic              ls_signed,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              mem_req_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_length,
  output logic              mem_signed,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              spurious_rsp
);

  logic [1:0]        state_q, state_d;
  logic              idle, force_if;
  logic              if_acc, ls_acc;
  logic              req_q, spur_q;
  logic              wr_q, sgn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        len_q;

  assign idle   = (state_q == ST_IDLE);
  assign if_req_ready = idle & if_req_valid
                      & (!ls_req_valid | force_if);
  assign ls_req_ready = idle & ls_req_valid
                      & !(force_if & if_req_valid);
  assign if_acc = if_req_ready;
  assign ls_acc = ls_req_ready;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i     (SYS_clk),
    .rst_i     (SYS_reset),
    .inc_i     (if_req_valid & !if_acc),
    .clr_i     (if_acc),
    .at_limit_o(force_if)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ls_acc)      state_d = ST_WAIT_LS;
        else if (if_acc) state_d = ST_WAIT_IF;
      end
      ST_WAIT_IF,
      ST_WAIT_LS: begin
        if (mem_rsp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      spur_q  <= 1'b0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= LEN_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= if_acc | ls_acc;
      if (idle && mem_rsp_valid)
        spur_q <= 1'b1;
      if (ls_acc) begin
        wr_q    <= ls_write;
        sgn_q   <= ls_signed;
        addr_q  <= ls_addr;
        wdata_q <= ls_wdata;
        len_q   <= ls_length;
      end else if (if_acc) begin
        wr_q    <= 1'b0;
        sgn_q   <= 1'b0;
        addr_q  <= if_addr;
        wdata_q <= '0;
        len_q   <= LEN_WORD;
      end
    end
  end

  assign mem_req_valid = req_q;
  assign mem_write     = wr_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_length    = len_q;
  assign mem_signed    = sgn_q;
  assign busy          = !idle;
  assign spurious_rsp  = spur_q;

  assign if_rsp_valid = (state_q == ST_WAIT_IF)
                      & mem_rsp_valid;
  assign ls_rsp_valid = (state_q == ST_WAIT_LS)
                      & mem_rsp_valid;
  assign if_rsp_data  = if_rsp_valid
                      ? mem_rsp_data : '0;
  // Store acks carry no data back to the core
  assign ls_rsp_data  = (ls_rsp_valid && !wr_q)
                      ? mem_rsp_data : '0;

endmodule
